// File: rtl/logic_gate_timed_pkg.sv
// Shared definitions for the run-time selectable timed logic gate:
// gate function encoding, implicit timing-state names and parameter limits.
package logic_pkg;

  // Gate function selected by the 3-bit mode input.
  typedef enum logic [2:0] {
    LG_AND  = 3'd0,
    LG_NAND = 3'd1,
    LG_OR   = 3'd2,
    LG_NOR  = 3'd3,
    LG_XOR  = 3'd4,
    LG_XNOR = 3'd5,
    LG_BUF  = 3'd6,
    LG_INV  = 3'd7
  } lg_mode_e;

  // The timer has only two meaningful situations: nothing pending (cnt==0)
  // or a transition toward ~y being timed (cnt!=0).
  typedef enum logic {
    LG_IDLE   = 1'b0,
    LG_TIMING = 1'b1
  } lg_state_e;

  // Legal parameter ranges.
  localparam int LG_MIN_N   = 2;
  localparam int LG_MAX_N   = 16;
  localparam int LG_MINDLY  = 1;
  localparam int LG_MAXDLY  = 255;

  // Larger of two integers, used to size the delay counter.
  function automatic int lg_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/logic_gate_timed_eval.sv
// Combinational function table of the N-input gate. BUF and INV look at
// a[0] only; XOR/XNOR are odd/even parity over all inputs.
module logic_eval
  import logic_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2:0]   mode,
  input  logic [N-1:0] a,
  output logic         f
);

  // Select the gate function for the current mode.
  always_comb begin
    f = 1'b0;
    case (lg_mode_e'(mode))
      LG_AND:  f = &a;
      LG_NAND: f = ~(&a);
      LG_OR:   f = |a;
      LG_NOR:  f = ~(|a);
      LG_XOR:  f = ^a;
      LG_XNOR: f = ~(^a);
      LG_BUF:  f = a[0];
      LG_INV:  f = ~a[0];
      default: f = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_gate_timed.sv
// Clocked N-input logic gate with separate rise/fall inertial delays.
// The output only moves once the evaluated function has disagreed with it
// for D consecutive enabled edges (D=RISE toward 1, D=FALL toward 0);
// shorter disagreements are swallowed and reported on a one-cycle glitch.
module logic_gate_timed
  import logic_pkg::*;
#(
  parameter int N         = 2,
  parameter int RISE      = 1,
  parameter int FALL      = 1,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic [N-1:0] a,
  output logic         y,
  output logic         busy,
  output logic         glitch
);

  // Counter must hold the longest delay; one extra bit is kept on the
  // incremented value so the compare against the target never wraps.
  localparam int MAXD = lg_max(RISE, FALL);
  localparam int CW   = $clog2(MAXD + 1);

  localparam logic [CW:0] RISE_W = (CW+1)'(RISE);
  localparam logic [CW:0] FALL_W = (CW+1)'(FALL);
  localparam logic [CW:0] ONE_W  = (CW+1)'(1);

  // Reject illegal configurations while elaborating.
  generate
    if (N < LG_MIN_N || N > LG_MAX_N) begin : g_bad_n
      $error("logic_gate_timed: N=%0d outside 2..16", N);
    end
    if (RISE < LG_MINDLY || RISE > LG_MAXDLY) begin : g_bad_rise
      $error("logic_gate_timed: RISE=%0d outside 1..255", RISE);
    end
    if (FALL < LG_MINDLY || FALL > LG_MAXDLY) begin : g_bad_fall
      $error("logic_gate_timed: FALL=%0d outside 1..255", FALL);
    end
  endgenerate

  logic          f;
  logic          y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          glitch_q, glitch_d;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   tgt;
  lg_state_e     state;

  logic_eval #(
    .N (N)
  ) u_eval (
    .mode (mode),
    .a    (a),
    .f    (f)
  );

  // Because y is binary, any disagreement times toward ~y; the target is
  // chosen purely by the value f is heading to.
  assign tgt     = f ? RISE_W : FALL_W;
  assign cnt_inc = {1'b0, cnt_q} + ONE_W;
  assign state   = (cnt_q != '0) ? LG_TIMING : LG_IDLE;

  // Next-state: hold everything when disabled; otherwise idle, swallow,
  // commit or keep counting, in that priority.
  always_comb begin
    y_d      = y_q;
    cnt_d    = cnt_q;
    glitch_d = 1'b0;
    if (en) begin
      case (state)
        LG_IDLE: begin
          if (f != y_q) begin
            if (cnt_inc == tgt) begin
              y_d = f;
            end else begin
              cnt_d = cnt_inc[CW-1:0];
            end
          end
        end
        LG_TIMING: begin
          if (f == y_q) begin
            // Disagreement ended before the delay expired.
            cnt_d    = '0;
            glitch_d = 1'b1;
          end else if (cnt_inc == tgt) begin
            y_d   = f;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end
    busy_d = (cnt_d != '0);
  end

  // State registers; reset abandons any pending transition silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= RESET_VAL;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign y      = y_q;
  assign busy   = busy_q;
  assign glitch = glitch_q;

endmodule

// File: tb/tb_logic_gate_timed.sv
// Scoreboard bench: the stimulus process predicts {y,busy,glitch} from a
// behavioural model and queues it; monitors pop and compare after each
// rising edge and right after an asynchronous reset assertion.
module tb_logic_gate_timed;

  localparam int N    = 4;
  localparam int RISE = 3;
  localparam int FALL = 2;
  localparam bit RV   = 1'b1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic [2:0]   mode  = 3'd0;
  logic [N-1:0] a     = '0;
  logic         y, busy, glitch;

  logic_gate_timed #(
    .N         (N),
    .RISE      (RISE),
    .FALL      (FALL),
    .RESET_VAL (RV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .a      (a),
    .y      (y),
    .busy   (busy),
    .glitch (glitch)
  );

  always #5 clk = ~clk;

  logic [2:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  // Reference model state: output level and length of the current run of
  // enabled edges at which the gate value disagreed with the output.
  bit m_y   = RV;
  int m_run = 0;
  bit m_gl  = 1'b0;

  function automatic bit ref_f(input int m, input logic [N-1:0] v);
    int ones;
    ones = $countones(v);
    case (m)
      0:       return ones == N;
      1:       return ones != N;
      2:       return ones > 0;
      3:       return ones == 0;
      4:       return (ones % 2) == 1;
      5:       return (ones % 2) == 0;
      6:       return v[0];
      default: return !v[0];
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    bit fv;
    int d;
    if (!rst_n) begin
      m_y = RV; m_run = 0; m_gl = 1'b0;
    end else if (!en) begin
      m_gl = 1'b0;
    end else begin
      fv = ref_f(int'(mode), a);
      if (fv == m_y) begin
        m_gl  = (m_run != 0);
        m_run = 0;
      end else begin
        m_gl  = 1'b0;
        m_run = m_run + 1;
        d = fv ? RISE : FALL;
        if (m_run == d) begin
          m_y   = fv;
          m_run = 0;
        end
      end
    end
  endtask

  task automatic pop_and_check(input string where);
    logic [2:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued at %0t, got y/busy/glitch=%b%b%b",
               where, $time, y, busy, glitch);
    end else begin
      e = exp_q.pop_front();
      if ({y, busy, glitch} !== e) begin
        errors++;
        $display("FAIL %s: got y/busy/glitch=%b%b%b expected %b%b%b at %0t (mode=%0d a=%b en=%b)",
                 where, y, busy, glitch, e[2], e[1], e[0], $time, mode, a, en);
      end
    end
  endtask

  // Monitor: output after every rising edge.
  always @(posedge clk) begin
    #1;
    if (mon_on) pop_and_check("cycle");
  end

  // Monitor: asynchronous reset must take effect without a clock edge.
  always @(negedge rst_n) begin
    #1;
    if (mon_on) pop_and_check("async_rst");
  end

  // Apply one cycle of stimulus on the falling edge and queue predictions.
  task automatic step(input bit r, input bit e, input logic [2:0] m,
                      input logic [N-1:0] v);
    @(negedge clk);
    if (!r && rst_n) begin
      m_y = RV; m_run = 0; m_gl = 1'b0;
      exp_q.push_back({RV, 1'b0, 1'b0});
    end
    rst_n  = r;
    en     = e;
    mode   = m;
    a      = v;
    mon_on = 1'b1;
    model_edge();
    exp_q.push_back({m_y, (m_run != 0), m_gl});
  endtask

  task automatic hold(input int n, input bit r, input bit e,
                      input logic [2:0] m, input logic [N-1:0] v);
    for (int i = 0; i < n; i++) step(r, e, m, v);
  endtask

  initial begin
    logic [2:0]   rm;
    logic [N-1:0] ra;
    bit           re, rr;

    // Reset held for a few edges.
    hold(3, 1'b0, 1'b0, 3'd0, 4'b0000);
    // AND with all ones: already matches y=1, idle.
    hold(3, 1'b1, 1'b1, 3'd0, 4'b1111);
    // Fall via AND: two edges.
    hold(3, 1'b1, 1'b1, 3'd0, 4'b0111);
    // Rise via AND: three edges after the last input goes high.
    hold(4, 1'b1, 1'b1, 3'd0, 4'b1111);
    // Fall when a[2] drops: two edges, no glitch.
    hold(3, 1'b1, 1'b1, 3'd0, 4'b1011);
    // OR settled at 0, then a two-edge pulse that must be swallowed.
    hold(3, 1'b1, 1'b1, 3'd2, 4'b0000);
    hold(2, 1'b1, 1'b1, 3'd2, 4'b0001);
    hold(3, 1'b1, 1'b1, 3'd2, 4'b0000);
    // Enable freeze in the middle of a rise.
    hold(1, 1'b1, 1'b1, 3'd2, 4'b0001);
    hold(5, 1'b1, 1'b0, 3'd2, 4'b0001);
    hold(3, 1'b1, 1'b1, 3'd2, 4'b0001);
    // Reset mid-count: y=0, count two edges toward 1, then reset.
    hold(3, 1'b1, 1'b1, 3'd2, 4'b0000);
    hold(2, 1'b1, 1'b1, 3'd2, 4'b0001);
    hold(2, 1'b0, 1'b1, 3'd2, 4'b0001);
    hold(4, 1'b1, 1'b1, 3'd2, 4'b0000);
    // Mode sweep over all eight functions.
    for (int m = 0; m < 8; m++) hold(4, 1'b1, 1'b1, 3'(m), 4'b0101);

    // Randomised traffic with held inputs so both delays and glitches occur.
    rm = 3'd0; ra = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) rm = 3'($urandom_range(7));
      if ($urandom_range(2) == 0) ra = N'($urandom);
      re = ($urandom_range(9) != 0);
      rr = ($urandom_range(99) != 0);
      step(rr, re, rm, ra);
    end

    // Let the last prediction be consumed, then confirm nothing is left.
    @(posedge clk);
    #2;
    mon_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
